// File: rtl/bomb_scoring_engine_pkg.sv
// -----------------------------------------------------------------------------
// battleship_pkg
// Shared types and constants for the Battleship scoring engine:
//   state_t       - FSM state encoding (IDLE / SCAN / REPORT)
//   ship_class_t  - one-hot ship class, patrol = LSB ... carrier = MSB
//   SHIP_CELLS    - total number of ship squares on the board
//   SHIP_LAYOUT   - the fixed fleet placement (1-based x/y, horizontal or vertical)
//   keep_msb()    - reduces a class mask to its highest set bit
// -----------------------------------------------------------------------------
package battleship_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SCAN   = 2'd1;
  localparam state_t ST_REPORT = 2'd2;

  typedef logic [4:0] ship_class_t;
  localparam ship_class_t CLASS_NONE = 5'b00000;
  localparam ship_class_t PATROL     = 5'b00001;
  localparam ship_class_t DESTROYER  = 5'b00010;
  localparam ship_class_t SUBMARINE  = 5'b00100;
  localparam ship_class_t BATTLESHIP = 5'b01000;
  localparam ship_class_t CARRIER    = 5'b10000;

  localparam int SHIP_CELLS = 19;
  localparam int NUM_SHIPS  = 6;

  // Last value of the 5x5 window counter (25 cells, 0..24)
  localparam logic [4:0] SCAN_LAST = 5'd24;

  typedef struct packed {
    logic [3:0]  x0;
    logic [3:0]  y0;
    logic [2:0]  len;
    logic        vertical;
    ship_class_t cls;
  } ship_t;

  // Fleet: 5 + 4 + 3 + 2 + 3 + 2 = 19 squares, no overlaps.
  // The carrier, battleship and submarine are stacked in the top-left corner
  // so a single big bomb there can sink most of three ships at once.
  localparam ship_t SHIP_LAYOUT [NUM_SHIPS] = '{
    '{x0: 4'd1, y0: 4'd1,  len: 3'd5, vertical: 1'b0, cls: CARRIER},
    '{x0: 4'd2, y0: 4'd2,  len: 3'd4, vertical: 1'b0, cls: BATTLESHIP},
    '{x0: 4'd3, y0: 4'd3,  len: 3'd3, vertical: 1'b0, cls: SUBMARINE},
    '{x0: 4'd7, y0: 4'd6,  len: 3'd2, vertical: 1'b0, cls: PATROL},
    '{x0: 4'd9, y0: 4'd8,  len: 3'd3, vertical: 1'b1, cls: DESTROYER},
    '{x0: 4'd1, y0: 4'd9,  len: 3'd2, vertical: 1'b0, cls: PATROL}
  };

  // Keeps only the most significant set bit so a merged mask stays one-hot
  function automatic ship_class_t keep_msb(input ship_class_t mask);
    ship_class_t result;
    result = CLASS_NONE;
    for (int i = 4; i >= 0; i--) begin
      if (mask[i] && (result == CLASS_NONE)) result[i] = 1'b1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bomb_scoring_engine_if.sv
// -----------------------------------------------------------------------------
// bomb_scoring_engine_if
// Request/result bundle between the board input debouncers (master) and the
// scoring engine (slave).
//   master -> slave : x, y, big, score
//   slave -> master : busy, done, is_hit, is_near_miss, is_miss, biggest_ship,
//                     hit_count, big_left, error, game_over
// -----------------------------------------------------------------------------
interface bomb_scoring_engine_if #(
  parameter int COORD_W = 4,
  parameter int HIT_W   = 5
);

  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               big;
  logic               score;

  logic               busy;
  logic               done;
  logic               is_hit;
  logic               is_near_miss;
  logic               is_miss;
  logic [4:0]         biggest_ship;
  logic [HIT_W-1:0]   hit_count;
  logic [1:0]         big_left;
  logic               error;
  logic               game_over;

  modport master (
    output x, y, big, score,
    input  busy, done, is_hit, is_near_miss, is_miss, biggest_ship,
           hit_count, big_left, error, game_over
  );

  modport slave (
    input  x, y, big, score,
    output busy, done, is_hit, is_near_miss, is_miss, biggest_ship,
           hit_count, big_left, error, game_over
  );

endinterface

// File: rtl/bomb_scoring_engine_ship_map.sv
// -----------------------------------------------------------------------------
// ship_map
// Combinational board lookup: returns the class of the ship occupying (x, y),
// or CLASS_NONE when the square is empty or off the board.
//   x, y : in  signed board coordinates (may be <1 or >GRID near the edges)
//   ship : out one-hot ship class
// -----------------------------------------------------------------------------
module ship_map
  import battleship_pkg::*;
#(
  parameter int GRID    = 10,
  parameter int COORD_W = 4
) (
  input  logic signed [COORD_W+1:0] x,
  input  logic signed [COORD_W+1:0] y,
  output ship_class_t               ship
);

  // Compare in plain integers so negative window offsets never alias onto
  // real squares; ships never overlap, so OR-ing matches is safe.
  always_comb begin
    int cx, cy, sx, sy, sl;
    ship = CLASS_NONE;
    cx   = int'(x);
    cy   = int'(y);
    sx   = 0;
    sy   = 0;
    sl   = 0;
    if ((cx >= 1) && (cx <= GRID) && (cy >= 1) && (cy <= GRID)) begin
      for (int i = 0; i < NUM_SHIPS; i++) begin
        sx = int'(SHIP_LAYOUT[i].x0);
        sy = int'(SHIP_LAYOUT[i].y0);
        sl = int'(SHIP_LAYOUT[i].len);
        if (SHIP_LAYOUT[i].vertical) begin
          if ((cx == sx) && (cy >= sy) && (cy < sy + sl)) ship = ship | SHIP_LAYOUT[i].cls;
        end else begin
          if ((cy == sy) && (cx >= sx) && (cx < sx + sl)) ship = ship | SHIP_LAYOUT[i].cls;
        end
      end
    end
  end

endmodule

// File: rtl/bomb_scoring_engine.sv
// -----------------------------------------------------------------------------
// bomb_scoring_engine
// Sequential Battleship scorer. A score pulse in IDLE validates the shot, then
// the engine walks a 5x5 window around the target one cell per clock (always
// 25 cycles), classifies the shot as hit / near miss / miss, marks newly struck
// squares, and reports for one cycle with done.
//   clock   : in  system clock, rising edge
//   reset_L : in  asynchronous active-low reset
//   bus     : slave side of bomb_scoring_engine_if (request in, results out)
// -----------------------------------------------------------------------------
module bomb_scoring_engine
  import battleship_pkg::*;
#(
  parameter int GRID      = 10,
  parameter int COORD_W   = 4,
  parameter int BIG_BOMBS = 2,
  parameter int HIT_W     = 5
) (
  input  logic                 clock,
  input  logic                 reset_L,
  bomb_scoring_engine_if.slave bus
);

  localparam logic [COORD_W-1:0] GRID_C = COORD_W'(GRID);
  localparam int                 IDX_W  = $clog2(GRID * GRID);

  state_t               state;
  logic [4:0]           scan_cnt;
  logic [COORD_W-1:0]   tgt_x;
  logic [COORD_W-1:0]   tgt_y;
  logic                 tgt_big;

  logic                 acc_hit;
  logic                 acc_near;
  ship_class_t          acc_class;

  logic                 res_hit;
  logic                 res_near;
  logic                 res_miss;
  ship_class_t          res_class;
  logic                 res_error;

  logic [HIT_W-1:0]     hit_count;
  logic [1:0]           big_left;
  logic [GRID*GRID-1:0] struck;

  logic                 game_over;
  logic                 reject;

  logic [2:0]           col_idx;
  logic [2:0]           row_idx;
  logic [2:0]           adx;
  logic [2:0]           ady;
  logic signed [COORD_W+1:0] cell_x;
  logic signed [COORD_W+1:0] cell_y;
  ship_class_t          cell_class;
  logic                 in_foot;
  logic                 in_near;
  logic                 foot_hit;
  logic                 near_hit;
  logic [IDX_W-1:0]     cell_idx;
  logic                 new_strike;
  ship_class_t          merged_class;

  assign game_over = (hit_count == HIT_W'(SHIP_CELLS));

  assign reject = (bus.x == '0) || (bus.x > GRID_C) ||
                  (bus.y == '0) || (bus.y > GRID_C) ||
                  (bus.big && (big_left == 2'd0)) ||
                  game_over;

  // Decode the window counter into row-major offsets (index 0..4 maps to
  // offset -2..+2) and the absolute distances used by the footprint rules.
  always_comb begin
    col_idx = 3'(scan_cnt % 5'd5);
    row_idx = 3'(scan_cnt / 5'd5);
    adx     = (col_idx >= 3'd2) ? (col_idx - 3'd2) : (3'd2 - col_idx);
    ady     = (row_idx >= 3'd2) ? (row_idx - 3'd2) : (3'd2 - row_idx);
    cell_x  = $signed({2'b00, tgt_x} + {{(COORD_W-1){1'b0}}, col_idx} - (COORD_W+2)'(2));
    cell_y  = $signed({2'b00, tgt_y} + {{(COORD_W-1){1'b0}}, row_idx} - (COORD_W+2)'(2));
  end

  ship_map #(
    .GRID    (GRID),
    .COORD_W (COORD_W)
  ) u_ship_map (
    .x    (cell_x),
    .y    (cell_y),
    .ship (cell_class)
  );

  // Small bomb strikes the centre and feels the 4-neighbours; a big bomb
  // strikes the 3x3 block and feels the outer ring minus its corners.
  always_comb begin
    if (tgt_big) begin
      in_foot = (adx <= 3'd1) && (ady <= 3'd1);
      in_near = ((adx == 3'd2) || (ady == 3'd2)) && !((adx == 3'd2) && (ady == 3'd2));
    end else begin
      in_foot = (adx == 3'd0) && (ady == 3'd0);
      in_near = ((adx + ady) == 3'd1);
    end
    foot_hit     = (cell_class != CLASS_NONE) && in_foot;
    near_hit     = (cell_class != CLASS_NONE) && in_near;
    merged_class = foot_hit ? keep_msb(acc_class | cell_class) : acc_class;
    cell_idx     = '0;
    if (cell_class != CLASS_NONE) begin
      cell_idx = IDX_W'((int'(cell_y) - 1) * GRID + (int'(cell_x) - 1));
    end
    new_strike = foot_hit && !struck[cell_idx];
  end

  // Control FSM, shot latching, scan accumulators and the registered result.
  // The last window cell is folded directly into the result on the exit edge
  // so the outputs are already settled in the done cycle.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state     <= ST_IDLE;
      scan_cnt  <= '0;
      tgt_x     <= '0;
      tgt_y     <= '0;
      tgt_big   <= 1'b0;
      acc_hit   <= 1'b0;
      acc_near  <= 1'b0;
      acc_class <= CLASS_NONE;
      res_hit   <= 1'b0;
      res_near  <= 1'b0;
      res_miss  <= 1'b0;
      res_class <= CLASS_NONE;
      res_error <= 1'b0;
      big_left  <= 2'(BIG_BOMBS);
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.score) begin
            if (reject) begin
              res_error <= 1'b1;
              res_hit   <= 1'b0;
              res_near  <= 1'b0;
              res_miss  <= 1'b0;
              res_class <= CLASS_NONE;
              state     <= ST_REPORT;
            end else begin
              tgt_x     <= bus.x;
              tgt_y     <= bus.y;
              tgt_big   <= bus.big;
              res_error <= 1'b0;
              acc_hit   <= 1'b0;
              acc_near  <= 1'b0;
              acc_class <= CLASS_NONE;
              scan_cnt  <= '0;
              if (bus.big) big_left <= big_left - 2'd1;
              state     <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (foot_hit) acc_hit <= 1'b1;
          if (near_hit) acc_near <= 1'b1;
          acc_class <= merged_class;
          if (scan_cnt == SCAN_LAST) begin
            res_hit   <= acc_hit | foot_hit;
            res_near  <= !(acc_hit | foot_hit) && (acc_near | near_hit);
            res_miss  <= !(acc_hit | foot_hit) && !(acc_near | near_hit);
            res_class <= merged_class;
            state     <= ST_REPORT;
          end else begin
            scan_cnt <= scan_cnt + 5'd1;
          end
        end
        ST_REPORT: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Struck-square bookkeeping: a square counts once, re-strikes still report
  // a hit but leave the counter alone. The counter saturates at all-ones.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      struck    <= '0;
      hit_count <= '0;
    end else if ((state == ST_SCAN) && new_strike) begin
      struck[cell_idx] <= 1'b1;
      if (hit_count != '1) hit_count <= hit_count + HIT_W'(1);
    end
  end

  assign bus.busy         = (state == ST_SCAN);
  assign bus.done         = (state == ST_REPORT);
  assign bus.is_hit       = res_hit;
  assign bus.is_near_miss = res_near;
  assign bus.is_miss      = res_miss;
  assign bus.biggest_ship = res_class;
  assign bus.hit_count    = hit_count;
  assign bus.big_left     = big_left;
  assign bus.error        = res_error;
  assign bus.game_over    = game_over;

endmodule

// File: tb/tb_bomb_scoring_engine.sv
// -----------------------------------------------------------------------------
// tb_bomb_scoring_engine
// Self-checking bench for bomb_scoring_engine: a directed vector table, a
// mid-scan reset sequence, randomized shots against a board-level reference
// model, and a full sweep of the fleet up to game over.
// -----------------------------------------------------------------------------
module tb_bomb_scoring_engine;

  logic clock;
  logic reset_L;

  int n_compared;
  int n_failed;

  // Reference model state (1-based board)
  int board    [1:10][1:10];
  bit m_struck [1:10][1:10];
  int m_hits;
  int m_big_left;
  bit m_hit, m_near, m_miss, m_err;
  int m_class;

  typedef struct {
    int x;
    int y;
    bit big;
    int done_cyc;
    bit hit;
    bit near;
    bit miss;
    bit err;
    int cls;
    int hits;
    int bl;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  bomb_scoring_engine_if #(.COORD_W(4), .HIT_W(5)) bus ();

  bomb_scoring_engine #(
    .GRID      (10),
    .COORD_W   (4),
    .BIG_BOMBS (2),
    .HIT_W     (5)
  ) dut (
    .clock   (clock),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic void place_ship(input int x0, input int y0, input int len,
                                     input bit vert, input int cls);
    for (int k = 0; k < len; k++) begin
      if (vert) board[x0][y0 + k] = cls;
      else      board[x0 + k][y0] = cls;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 1; i <= 10; i++)
      for (int j = 1; j <= 10; j++) m_struck[i][j] = 1'b0;
    m_hits     = 0;
    m_big_left = 2;
    m_hit = 1'b0; m_near = 1'b0; m_miss = 1'b0; m_err = 1'b0;
    m_class    = 0;
  endfunction

  // Scores one shot from the game rules directly: footprint and neighbourhood
  // by distance, largest class by numeric value of the one-hot code.
  function automatic void model_shot(input int sx, input int sy, input bit sb);
    bit h, n;
    int c, cx, cy, adx, ady, mx;
    bit foot, near;
    if (sx < 1 || sx > 10 || sy < 1 || sy > 10 || (sb && m_big_left == 0) || m_hits == 19) begin
      m_err = 1'b1; m_hit = 1'b0; m_near = 1'b0; m_miss = 1'b0; m_class = 0;
      return;
    end
    m_err = 1'b0;
    if (sb) m_big_left--;
    h = 1'b0; n = 1'b0; c = 0;
    for (int dy = -2; dy <= 2; dy++) begin
      for (int dx = -2; dx <= 2; dx++) begin
        cx = sx + dx;
        cy = sy + dy;
        if (cx < 1 || cx > 10 || cy < 1 || cy > 10) continue;
        if (board[cx][cy] == 0) continue;
        adx  = (dx < 0) ? -dx : dx;
        ady  = (dy < 0) ? -dy : dy;
        mx   = (adx > ady) ? adx : ady;
        foot = sb ? (mx <= 1) : (adx == 0 && ady == 0);
        near = sb ? (mx == 2 && !(adx == 2 && ady == 2)) : (adx + ady == 1);
        if (foot) begin
          h = 1'b1;
          if (board[cx][cy] > c) c = board[cx][cy];
          if (!m_struck[cx][cy]) begin
            m_struck[cx][cy] = 1'b1;
            if (m_hits < 31) m_hits++;
          end
        end else if (near) begin
          n = 1'b1;
        end
      end
    end
    m_hit   = h;
    m_near  = !h && n;
    m_miss  = !h && !n;
    m_class = c;
  endfunction

  // Fires one shot and follows it until done (bounded). Returns the done
  // cycle (-1 on timeout), busy cycle count, big_left seen in cycle 1 and the
  // result flags seen in cycle 12.
  task automatic apply_stimulus(input int sx, input int sy, input bit sb,
                                output int done_cyc, output int busy_cnt,
                                output int bl_c1, output int mid_flags);
    done_cyc  = -1;
    busy_cnt  = 0;
    bl_c1     = -1;
    mid_flags = -1;
    repeat (2) @(negedge clock);
    bus.x     = 4'(sx);
    bus.y     = 4'(sy);
    bus.big   = sb;
    bus.score = 1'b1;
    @(posedge clock);
    #1;
    bus.score = 1'b0;
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      if (cyc > 1) begin
        @(posedge clock);
        #1;
      end
      if (bus.busy) busy_cnt++;
      if (cyc == 1) bl_c1 = int'(bus.big_left);
      if (cyc == 12) mid_flags = int'({bus.is_hit, bus.is_near_miss, bus.is_miss});
      if (bus.done) done_cyc = cyc;
    end
  endtask

  task automatic run_checked_shot(input string tag, input int sx, input int sy, input bit sb);
    int dc, bc, bl1, mf;
    apply_stimulus(sx, sy, sb, dc, bc, bl1, mf);
    model_shot(sx, sy, sb);
    check_output({tag, "_done_cyc"}, dc, m_err ? 1 : 26);
    check_output({tag, "_busy_cycles"}, bc, m_err ? 0 : 25);
    check_output({tag, "_is_hit"}, int'(bus.is_hit), int'(m_hit));
    check_output({tag, "_is_near_miss"}, int'(bus.is_near_miss), int'(m_near));
    check_output({tag, "_is_miss"}, int'(bus.is_miss), int'(m_miss));
    check_output({tag, "_error"}, int'(bus.error), int'(m_err));
    check_output({tag, "_biggest_ship"}, int'(bus.biggest_ship), m_class);
    check_output({tag, "_hit_count"}, int'(bus.hit_count), m_hits);
    check_output({tag, "_big_left"}, int'(bus.big_left), m_big_left);
    check_output({tag, "_big_left_c1"}, bl1, m_big_left);
    check_output({tag, "_game_over"}, int'(bus.game_over), int'(m_hits == 19));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_busy"}, int'(bus.busy), 0);
    check_output({tag, "_done"}, int'(bus.done), 0);
    check_output({tag, "_flags"}, int'({bus.is_hit, bus.is_near_miss, bus.is_miss}), 0);
    check_output({tag, "_biggest_ship"}, int'(bus.biggest_ship), 0);
    check_output({tag, "_hit_count"}, int'(bus.hit_count), 0);
    check_output({tag, "_big_left"}, int'(bus.big_left), 2);
    check_output({tag, "_error"}, int'(bus.error), 0);
    check_output({tag, "_game_over"}, int'(bus.game_over), 0);
  endtask

  initial begin
    int dc, bc, bl1, mf, dones, sx, sy;
    bit sb;

    n_compared = 0;
    n_failed   = 0;
    bus.x = '0; bus.y = '0; bus.big = 1'b0; bus.score = 1'b0;
    reset_L = 1'b0;

    for (int i = 1; i <= 10; i++)
      for (int j = 1; j <= 10; j++) board[i][j] = 0;
    place_ship(1, 1, 5, 1'b0, 16);
    place_ship(2, 2, 4, 1'b0, 8);
    place_ship(3, 3, 3, 1'b0, 4);
    place_ship(7, 6, 2, 1'b0, 1);
    place_ship(9, 8, 3, 1'b1, 2);
    place_ship(1, 9, 2, 1'b0, 1);
    model_reset();

    //            x  y  big   done hit   near  miss  err   cls hits bl
    vecs[0] = '{7, 6, 1'b0, 26, 1'b1, 1'b0, 1'b0, 1'b0, 1,  1,  2};
    vecs[1] = '{7, 6, 1'b0, 26, 1'b1, 1'b0, 1'b0, 1'b0, 1,  1,  2};
    vecs[2] = '{6, 5, 1'b0, 26, 1'b0, 1'b0, 1'b1, 1'b0, 0,  1,  2};
    vecs[3] = '{7, 7, 1'b0, 26, 1'b0, 1'b1, 1'b0, 1'b0, 0,  1,  2};
    vecs[4] = '{3, 2, 1'b1, 26, 1'b1, 1'b0, 1'b0, 1'b0, 16, 9,  1};
    vecs[5] = '{0, 5, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b1, 0,  9,  1};
    vecs[6] = '{5, 11, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 0,  9,  1};
    vecs[7] = '{8, 8, 1'b1, 26, 1'b1, 1'b0, 1'b0, 1'b0, 2,  11, 0};
    vecs[8] = '{5, 5, 1'b1, 1,  1'b0, 1'b0, 1'b0, 1'b1, 0,  11, 0};
    vecs[9] = '{2, 9, 1'b0, 26, 1'b1, 1'b0, 1'b0, 1'b0, 1,  12, 0};

    repeat (3) @(negedge clock);
    check_reset_outputs("in_reset");
    reset_L = 1'b1;
    @(negedge clock);
    check_reset_outputs("after_reset");

    $display("[TB] directed vector table");
    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i].x, vecs[i].y, vecs[i].big, dc, bc, bl1, mf);
      check_output($sformatf("v%0d_done_cyc", i), dc, vecs[i].done_cyc);
      check_output($sformatf("v%0d_busy_cycles", i), bc, vecs[i].err ? 0 : 25);
      check_output($sformatf("v%0d_is_hit", i), int'(bus.is_hit), int'(vecs[i].hit));
      check_output($sformatf("v%0d_is_near_miss", i), int'(bus.is_near_miss), int'(vecs[i].near));
      check_output($sformatf("v%0d_is_miss", i), int'(bus.is_miss), int'(vecs[i].miss));
      check_output($sformatf("v%0d_error", i), int'(bus.error), int'(vecs[i].err));
      check_output($sformatf("v%0d_biggest_ship", i), int'(bus.biggest_ship), vecs[i].cls);
      check_output($sformatf("v%0d_hit_count", i), int'(bus.hit_count), vecs[i].hits);
      check_output($sformatf("v%0d_big_left", i), int'(bus.big_left), vecs[i].bl);
      check_output($sformatf("v%0d_big_left_c1", i), bl1, vecs[i].bl);
      check_output($sformatf("v%0d_game_over", i), int'(bus.game_over), 0);
      if (!vecs[i].err && i > 0) begin
        check_output($sformatf("v%0d_result_hold", i), mf,
                     int'({vecs[i-1].hit, vecs[i-1].near, vecs[i-1].miss}));
      end
    end

    $display("[TB] reset in the middle of a scan");
    repeat (2) @(negedge clock);
    bus.x = 4'd1; bus.y = 4'd9; bus.big = 1'b0; bus.score = 1'b1;
    @(posedge clock);
    #1;
    bus.score = 1'b0;
    repeat (11) @(posedge clock);
    #1;
    check_output("midscan_busy_c12", int'(bus.busy), 1);
    dones = 0;
    reset_L = 1'b0;
    #1;
    check_reset_outputs("midscan_reset");
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (bus.done) dones++;
    end
    reset_L = 1'b1;
    model_reset();
    for (int k = 0; k < 30; k++) begin
      @(posedge clock);
      #1;
      if (bus.done) dones++;
    end
    check_output("midscan_no_done", dones, 0);
    run_checked_shot("restrike_after_reset", 7, 6, 1'b0);

    $display("[TB] randomized shots against the reference model");
    for (int n = 0; n < 40; n++) begin
      sx = int'($urandom_range(0, 11));
      sy = int'($urandom_range(0, 11));
      sb = ($urandom_range(0, 3) == 0);
      run_checked_shot($sformatf("rnd%0d", n), sx, sy, sb);
    end

    $display("[TB] sweeping every ship square");
    for (int cy = 1; cy <= 10; cy++) begin
      for (int cx = 1; cx <= 10; cx++) begin
        if (board[cx][cy] != 0) run_checked_shot($sformatf("sweep_%0d_%0d", cx, cy), cx, cy, 1'b0);
      end
    end
    check_output("final_hit_count", int'(bus.hit_count), 19);
    check_output("final_game_over", int'(bus.game_over), 1);
    run_checked_shot("after_game_over", 7, 7, 1'b0);
    check_output("after_game_over_error", int'(bus.error), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/bomb_scoring_engine.md
# bomb_scoring_engine

Sequential Battleship scoring engine that replaces the combinational bomb checker. On a `score` pulse it validates the shot, then scans a fixed 5×5 window around the target one cell per clock. It classifies the shot as hit, near miss or miss, tracks already-struck squares, and maintains a running hit count and the stock of big bombs. It sits between the board switch/key debouncers and the LED/seven-segment display drivers.

## Interface
- `GRID` — default 10 — board edge length; legal coordinates are 1..GRID.
- `COORD_W` — default 4 — coordinate width.
- `BIG_BOMBS` — default 2 — big bombs available after reset (max 3).
- `HIT_W` — default 5 — hit counter width; must hold `SHIP_CELLS`.
- `clock` — in, 1 — system clock, rising edge.
- `reset_L` — in, 1 — asynchronous, active-low reset.
- `x`, `y` — in, COORD_W each — target column and row.
- `big` — in, 1 — use a big bomb for this shot.
- `score` — in, 1 — single-cycle request pulse.
- `busy` — out, 1 — scan in progress.
- `done` — out, 1 — one-cycle pulse; result outputs are valid from this cycle.
- `is_hit`, `is_near_miss`, `is_miss` — out, 1 each — result of the last shot; exactly one is set after a valid shot.
- `biggest_ship` — out, 5 — one-hot largest ship class struck by the last shot.
- `hit_count` — out, HIT_W — distinct ship squares struck since reset.
- `big_left` — out, 2 — big bombs remaining.
- `error` — out, 1 — last request was rejected.
- `game_over` — out, 1 — `hit_count == SHIP_CELLS`.

## Operation
- Reset values:
  - `big_left` = BIG_BOMBS.
  - Every other output = 0.
  - Struck bitmap cleared.
  - FSM in IDLE.
- FSM states are IDLE, SCAN and REPORT.
- IDLE + `score` performs validation. The request is rejected if any of these holds:
  - `x` or `y` is outside 1..GRID.
  - `big` is set and `big_left` = 0.
  - `game_over` is set.
- On rejection: go to REPORT directly. Set `error`=1; clear `is_*` and `biggest_ship`; leave the counters unchanged.
- On acceptance:
  - Latch `x`, `y` and `big`.
  - Clear `error` and the scan accumulators.
  - If `big` is set, decrement `big_left`.
  - Move to SCAN with offset (dx,dy) = (−2,−2).
- SCAN visits dx, dy ∈ −2..2, row-major, one cell per cycle, always 25 cycles. Cells that fall off the board read as empty.
- Footprint:
  - Small bomb: the centre cell only.
  - Big bomb: cells with |dx|≤1 and |dy|≤1.
- Neighbourhood:
  - Small bomb: cells with |dx|+|dy| = 1.
  - Big bomb: cells with max(|dx|,|dy|) = 2, excluding the four corners.
  - All other window cells are ignored.
- Occupied footprint cell:
  - Set the hit accumulator.
  - OR its class into `biggest_ship` and keep only the MSB, so the result stays one-hot.
  - If the cell is not yet in the struck bitmap, set its bit and increment `hit_count`, saturating at all-ones.
- Occupied neighbourhood cell: set the near accumulator.
- REPORT lasts one cycle:
  - Drive `done`=1.
  - Set the result flags with priority hit > near miss > miss.
  - Return to IDLE.
- Re-striking a square that is already struck:
  - `is_hit`=1 and `biggest_ship` reflects the ship.
  - `hit_count` is unchanged.
- `score` is ignored while `busy` is high or in REPORT.

## Timing
- An accepted request sampled at edge 0 gives `busy`=1 on cycles 1–25 and `done`=1 on cycle 26.
- Results, `hit_count` and `big_left` are registered and update no later than the `done` cycle.
- Results hold until the next `done`.
- A rejected request gives `done` and `error` on cycle 1, with `busy` never asserted.
- `big_left` decrements on cycle 1 of an accepted big shot.
- `game_over` is combinational from `hit_count`.
- Asserting `reset_L` low mid-scan immediately returns every output and the bitmap to reset values; no `done` is produced.

## Structure
- `battleship_pkg` contains:
  - `state_t` for IDLE/SCAN/REPORT.
  - `ship_class_t`, 5-bit one-hot (patrol=00001 … carrier=10000).
  - `SHIP_CELLS` = 19.
  - The fixed ship layout constants.
- Sub-module `ship_map` is a combinational lookup from (x, y) to `ship_class_t`, returning 0 when empty or off-board.
- Core logic: one FSM, a 5-bit scan counter, and a GRID×GRID struck bitmap.

## Test plan
- Reset, then small bomb at (7,6) → `done` on cycle 26, `is_hit`=1, `biggest_ship`=00001, `hit_count`=1, `big_left`=2.
- Repeat the same shot at (7,6) → `is_hit`=1, `hit_count` stays 1.
- Small bomb at (6,5) → `is_near_miss`=1 via (7,5)? No: (7,5) is empty, and (6,6) is also empty, so the result is `is_miss`=1. Then small bomb at (7,7) → `is_near_miss`=1 through (7,6).
- Big bomb at (3,2) → `is_hit`=1, `biggest_ship`=10000, `hit_count` +8, `big_left`=1. Fire two more big bombs; the third → `error`=1, `done` on cycle 1, `big_left`=0.
- Shot at x=0 or y=11 → `error`=1, `busy` never set, counters unchanged.
- Drive `reset_L` low at scan cycle 12 → all outputs return to reset values and no `done`. Then strike all 19 cells → `game_over`=1, and the next shot → `error`=1.
